// File: rtl/encoder16x4_serial_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | encoder16x4_serial_if : request/code handshake bundle              |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface encoder16x4_serial_if;
  logic [15:0] req;
  logic        load;
  logic        ready;
  logic        valid;
  logic [3:0]  code;
  logic        last;
  logic [4:0]  cnt;
  logic        busy;
  logic        none;

  modport master (
    output req, load, ready,
    input  valid, code, last, cnt, busy, none
  );

  modport slave (
    input  req, load, ready,
    output valid, code, last, cnt, busy, none
  );
endinterface
`default_nettype wire

// File: rtl/encoder16x4_serial.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | encoder16x4_serial : emits indices of set request bits, low first  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module encoder16x4_serial (
  input  wire logic             clk,
  input  wire logic             rst,
  encoder16x4_serial_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic        none_q, none_d;

  logic [3:0]  low_idx;
  logic [4:0]  pop_cnt;
  logic        in_busy;

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    low_idx = 4'd0;
    pop_cnt = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pend_q[i]) low_idx = 4'(i);
    end
    for (int i = 0; i < 16; i++) begin
      pop_cnt = pop_cnt + 5'(pend_q[i]);
    end
  end

  assign in_busy   = (state_q == ST_BUSY);
  assign bus.busy  = in_busy;
  assign bus.valid = in_busy;
  assign bus.code  = in_busy ? low_idx : 4'd0;
  assign bus.cnt   = in_busy ? pop_cnt : 5'd0;
  assign bus.last  = in_busy && (pop_cnt == 5'd1);
  assign bus.none  = none_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    none_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (bus.load) begin
        if (bus.req != 16'd0) begin
          pend_d  = bus.req;
          state_d = ST_BUSY;
        end else begin
          none_d = 1'b1;
        end
      end
    end else begin
      if (bus.ready) begin
        pend_d = pend_q & ~(16'd1 << low_idx);
        if (pop_cnt == 5'd1) state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= 16'd0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      none_q  <= none_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_encoder16x4_serial.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_encoder16x4_serial : scoreboard bench for encoder16x4_serial    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_encoder16x4_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  encoder16x4_serial_if bus ();

  encoder16x4_serial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] code;
    logic       last;
    logic [4:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] dec2x4(input logic en, input logic [1:0] a);
    dec2x4 = en ? (4'b0001 << a) : 4'b0000;
  endfunction

  // Reference 4x16 decoder assembled from 2x4 stages.
  function automatic logic [15:0] dec4x16(input logic [3:0] c);
    logic [3:0] hi;
    hi = dec2x4(1'b1, c[3:2]);
    for (int j = 0; j < 4; j++) dec4x16[4*j +: 4] = dec2x4(hi[j], c[1:0]);
  endfunction

  task automatic push_expected(input logic [15:0] r);
    int rem;
    exp_t e;
    rem = $countones(r);
    for (int i = 0; i < 16; i++) begin
      if (r[i]) begin
        e.code = 4'(i);
        e.last = (rem == 1);
        e.cnt  = 5'(rem);
        sb.push_back(e);
        rem--;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] r, input bit accepted);
    bus.req  = r;
    bus.load = 1'b1;
    if (accepted) push_expected(r);
    step();
    bus.load = 1'b0;
    bus.req  = 16'd0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      step();
      n++;
    end
    chk(name, {31'd0, bus.busy}, 32'd0);
  endtask

  // Monitor: every accepted code is matched against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.valid && bus.ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("code", 32'(bus.code), 32'(e.code));
        chk("last", 32'(bus.last), 32'(e.last));
        chk("cnt",  32'(bus.cnt),  32'(e.cnt));
        chk("decode", 32'(dec4x16(bus.code)), 32'(16'd1 << e.code));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req   = 16'd0;
    bus.load  = 1'b0;
    bus.ready = 1'b1;
    rst       = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_code",  32'(bus.code),  32'd0);
    chk("rst_cnt",   32'(bus.cnt),   32'd0);
    chk("rst_last",  32'(bus.last),  32'd0);
    chk("rst_none",  32'(bus.none),  32'd0);

    // Two-bit burst at the extremes of the vector.
    do_load(16'h8001, 1'b1);
    chk("8001_busy", 32'(bus.busy), 32'd1);
    chk("8001_cnt0", 32'(bus.cnt),  32'd2);
    step();
    chk("8001_code1", 32'(bus.code), 32'd15);
    step();
    chk("8001_busy_end",  32'(bus.busy),  32'd0);
    chk("8001_valid_end", 32'(bus.valid), 32'd0);
    chk("8001_cnt_end",   32'(bus.cnt),   32'd0);

    // Full vector: sixteen back-to-back codes without a gap.
    do_load(16'hFFFF, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk("ffff_valid", 32'(bus.valid), 32'd1);
      step();
    end
    chk("ffff_busy_end", 32'(bus.busy), 32'd0);

    // Backpressure holds the presented code stable.
    bus.ready = 1'b0;
    do_load(16'h0024, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_code",  32'(bus.code),  32'd2);
      chk("bp_cnt",   32'(bus.cnt),   32'd2);
      chk("bp_valid", 32'(bus.valid), 32'd1);
      step();
    end
    bus.ready = 1'b1;
    step();
    chk("bp_code2", 32'(bus.code), 32'd5);
    chk("bp_last2", 32'(bus.last), 32'd1);
    step();
    chk("bp_busy_end", 32'(bus.busy), 32'd0);

    // Zero request produces a single none pulse.
    do_load(16'h0000, 1'b0);
    chk("zero_none",  32'(bus.none),  32'd1);
    chk("zero_valid", 32'(bus.valid), 32'd0);
    chk("zero_busy",  32'(bus.busy),  32'd0);
    step();
    chk("zero_none_off", 32'(bus.none), 32'd0);

    // Load while busy is ignored.
    bus.ready = 1'b0;
    do_load(16'h0030, 1'b1);
    do_load(16'h0100, 1'b0);
    chk("ign_code", 32'(bus.code), 32'd4);
    chk("ign_cnt",  32'(bus.cnt),  32'd2);
    chk("ign_none", 32'(bus.none), 32'd0);
    bus.ready = 1'b1;
    wait_idle("ign_idle");

    // Reset mid-burst discards pending bits.
    do_load(16'h00F0, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_valid", 32'(bus.valid), 32'd0);
    chk("mid_rst_busy",  32'(bus.busy),  32'd0);
    chk("mid_rst_cnt",   32'(bus.cnt),   32'd0);
    chk("mid_rst_code",  32'(bus.code),  32'd0);
    chk("mid_rst_last",  32'(bus.last),  32'd0);
    do_load(16'h0001, 1'b1);
    chk("post_rst_code", 32'(bus.code), 32'd0);
    wait_idle("post_rst_idle");

    // Loopback through the reference decoder for every single-bit request.
    for (int i = 0; i < 16; i++) begin
      do_load(16'd1 << i, 1'b1);
      chk("loop_dec",  32'(dec4x16(bus.code)), 32'(16'd1 << i));
      chk("loop_last", 32'(bus.last), 32'd1);
      step();
    end
    chk("loop_idle", 32'(bus.busy), 32'd0);

    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/encoder16x4_serial.md
# encoder16x4_serial

Sequential 16-to-4 encoder: captures a 16-bit request vector and emits the 4-bit index of every set bit, lowest index first, one code per valid/ready handshake. It is the inverse of the 4x16 decoder built from 2x4 stages. A code produced here and driven into that decoder yields a one-hot word with exactly the originating request bit set. It sits between request-collection logic and any consumer that serialises one index at a time.

## Interface

Parameters: none; widths are fixed at 16 requests and 4-bit codes.

- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req  in  16  request vector; sampled only when a load is accepted
- load  in  1  capture request; accepted only while busy=0
- ready  in  1  consumer accepts the current code
- valid  out  1  code is presented
- code  out  4  index of lowest set bit still pending
- last  out  1  current code is the final one of the burst
- cnt  out  5  number of set bits still pending, 0..16
- busy  out  1  burst in progress; load ignored
- none  out  1  one-cycle pulse: load accepted with req==0

## Operation

- State: two-state FSM (IDLE, BUSY) and a 16-bit pending mask `pend`.
- Reset (rst=1 at an edge):
  - pend=0, state=IDLE.
  - valid=0, code=0, last=0, cnt=0, busy=0, none=0.
  - Reset overrides everything, including load and a handshake in the same cycle.
  - Reset mid-burst discards all pending bits.
- IDLE:
  - busy=0, valid=0, code=0, last=0, cnt=0.
  - load=1 and req!=0: pend<=req, go BUSY.
  - load=1 and req==0: stay IDLE, none=1 for the next cycle only.
  - load=0: hold.
- BUSY:
  - busy=1, valid=1.
  - code = index of lowest set bit of pend (bit 0 has highest priority).
  - cnt = popcount(pend).
  - last = 1 iff cnt==1.
- Handshake (valid & ready at an edge):
  - Clear bit `code` in pend.
  - If last=1, go IDLE.
  - valid & !ready: pend, code, cnt and last hold stable, with no change for any number of cycles.
- load while busy=1 is ignored: pend is not modified and no none pulse is generated.
- All outputs derive from registered state (pend, FSM, none flop). There is no combinational path from req, load or ready to any output.
- Width rules: cnt is 5 bits so that 16 is representable. code is always within 0..15.

## Timing

- Load latency: load accepted at edge N → valid=1 with the first code during cycle N+1.
- Throughput: with ready held at 1, one code per cycle. A burst of k bits completes in k cycles after the load edge.
- End of burst: on the edge that accepts the last code, valid, busy, last and cnt all fall together in the following cycle.
- Reload: the earliest new load is accepted at the edge after busy is observed low. There is no same-cycle reload on the last handshake, since busy is still 1 in that cycle.
- none: asserted exactly one cycle, in the cycle after the zero-request load edge.
- Reset: outputs reach their reset values in the cycle after the rst edge.

## Test plan

- load with req=16'h8001, ready=1 → codes 0 then 15 in consecutive cycles; cnt 2 then 1; last=1 only with code 15; busy=0 in the cycle after.
- load with req=16'hFFFF, ready=1 throughout → codes 0..15 on 16 consecutive cycles; cnt counts 16 down to 1; valid never drops mid-burst.
- Backpressure: load req=16'h0024, hold ready=0 for 3 cycles → code=2, cnt=2 stable for all 3 cycles; then ready=1 → code 2 accepted, then code 5 with last=1.
- Zero request: load with req=16'h0000 → none=1 for exactly one cycle, valid and busy stay 0. Separately, load with req=16'h0100 while busy → ignored; the burst in progress continues unchanged.
- Reset mid-burst: load req=16'h00F0, accept one code, assert rst → next cycle all outputs 0 and state IDLE; a subsequent load of 16'h0001 yields code 0.
- Loopback: for each i in 0..15, load req=1<<i and drive the emitted code into the 4x16 decoder → decoder output equals 1<<i, and last=1.
